ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  Parametrised AHB-Lite slave with integrated word-addressed SRAM. Generalises ahb_slave_wrapper:
//  configurable width/depth, programmable wait states, HSIZE/Hstrob byte-lane writes,
//  read-after-write forwarding and two-cycle ERROR response. Sits behind the AHB decoder/mux.
// PARAMETERS
//  DATA_WIDTH   32  data bus width; 32 or 64
//  ADDR_WIDTH   32  address bus width
//  MEM_DEPTH    1024 words of DATA_WIDTH; byte range 0 .. MEM_DEPTH*DATA_WIDTH/8-1
//  WAIT_STATES  0   Hreadyout-low cycles per data phase; 0..15
// PORTS
//  Hclk       in   1             bus clock
//  Hreset     in   1             async reset, active-high
//  Haddr      in   ADDR_WIDTH    byte address (address phase)
//  Htrans     in   2             00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  Hwrite     in   1             1 write, 0 read
//  Hsize      in   3             transfer size, 2**Hsize bytes
//  Hburst     in   3             burst type; no effect on behaviour
//  HWdata     in   DATA_WIDTH    write data (data phase)
//  Hstrob     in   DATA_WIDTH/8  write byte strobes (data phase), ANDed with size lanes
//  Hsel       in   1             slave select
//  Hready     in   1             bus ready (previous transfer done)
//  HRdata     out  DATA_WIDTH    read data
//  Hreadyout  out  1             this slave's ready
//  Hresp      out  2             00 OKAY, 01 ERROR
// BEHAVIOUR
//  - Accept when Hsel & Hready & Htrans[1]; register addr, size, write, lanes. IDLE/BUSY or
//    unselected -> OKAY zero-wait, no access.
//  - LSB=log2(DATA_WIDTH/8); word index = Haddr[LSB +: clog2(MEM_DEPTH)]; lanes = (2**Hsize)
//    ones shifted by Haddr[LSB-1:0].
//  - FSM: IDLE, WAIT, ERR1, ERR2. Accepted legal transfer -> WAIT if WAIT_STATES>0 (counter
//    loads WAIT_STATES, Hreadyout=0, decrements to 0, then final cycle Hreadyout=1), else
//    final cycle immediately. Final cycle: write commits HWdata on lanes&Hstrob at Hclk edge;
//    read drives HRdata = mem word. HRdata=0 in all non-final-read cycles.
//  - Pipelining: new address phase accepted in any final cycle (OKAY or ERR2) -> back-to-back
//    zero-wait transfers sustain 1 transfer/cycle.
//  - Forwarding: read whose data phase immediately follows a write to same word returns
//    merged data (new bytes on written lanes, old elsewhere); never stale.
//  - Reset (async, any cycle): state IDLE, counter 0, Hreadyout=1, Hresp=00, HRdata=0,
//    pending write dropped; SRAM contents not reset/undefined.
//  - Hresp=00 in every cycle outside ERR1/ERR2.
// CONFIGURATION
//  AHB_SLV_ERR_EN defined: illegal transfer = Hsize>LSB, Haddr not aligned to 2**Hsize, or
//    word index >= MEM_DEPTH (address bits above index nonzero). Illegal -> ERR1 (Hreadyout=0,
//    Hresp=01), then ERR2 (Hreadyout=1, Hresp=01), no wait states, no write, HRdata=0.
//    ERR2 is a final cycle (may accept next transfer); IDLE in ERR1 does not cancel ERR2.
//  Not defined: no ERR states; Hresp tied 00; Hsize>LSB clamped to LSB; unaligned lanes
//    computed from aligned-down address; index taken modulo MEM_DEPTH (alias wrap).
// TESTING
//  1. WAIT_STATES=0: NONSEQ write 0x10 data 0xDEADBEEF, next-cycle read 0x10 -> HRdata
//     0xDEADBEEF, Hreadyout=1 both cycles (forwarding).
//  2. WAIT_STATES=2: read 0x20 -> Hreadyout 0,0,1; HRdata valid only in 3rd data cycle.
//  3. Word 0x30=0x11223344; byte write Hsize=0 0x31 data 0x0000AA00 -> read 0x30 = 0x1122AA44;
//     Hstrob=0 on full-word write -> word unchanged.
//  4. AHB_SLV_ERR_EN, MEM_DEPTH=1024: read 0x1000 or Hsize=2 at 0x02 -> Hresp 01/01,
//     Hreadyout 0/1; subsequent write to 0x1000 leaves mem[0] unchanged.
//  5. Assert Hreset in WAIT cycle of write 0x40=0x55 -> outputs to reset values, read 0x40
//     returns prior content.
//  6. 4-beat INCR4 SEQ with BUSY inserted -> BUSY OKAY zero-wait, all 4 beats at 0x50..0x5C.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave with word-addressed byte-lane SRAM, programmable wait states and RAW forwarding.
// Define AHB_SLV_ERR_EN to answer illegal transfers with a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                    Hclk,
  input  logic                    Hreset,
  input  logic [ADDR_WIDTH-1:0]   Haddr,
  input  logic [1:0]              Htrans,
  input  logic                    Hwrite,
  input  logic [2:0]              Hsize,
  input  logic [2:0]              Hburst,
  input  logic [DATA_WIDTH-1:0]   HWdata,
  input  logic [DATA_WIDTH/8-1:0] Hstrob,
  input  logic                    Hsel,
  input  logic                    Hready,
  output logic [DATA_WIDTH-1:0]   HRdata,
  output logic                    Hreadyout,
  output logic [1:0]              Hresp
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  // WAIT spans the whole data phase of a legal transfer; its last cycle (cnt_reg == 0) is final.
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              write_reg;
  logic [STRB_W-1:0] lanes_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [STRB_W-1:0] fwd_mask_reg;
  logic [DATA_WIDTH-1:0] fwd_data_reg;

  logic              accept, take, illegal;
  logic [2:0]        size_eff;
  logic [LSB-1:0]    byte_off, size_mask;
  logic [15:0]       lane_ones;
  logic [STRB_W-1:0] acc_lanes;
  logic [IDX_W-1:0]  acc_idx;
  logic              final_cyc, wr_commit;
  logic [STRB_W-1:0] wr_be;
  logic [DATA_WIDTH-1:0] rd_word, fwd_bits;

  logic unused_ok;
  assign unused_ok = ^{Hburst, Htrans[0], Haddr};

  always_comb begin
    accept    = Hsel & Hready & Htrans[1];
    acc_idx   = Haddr[LSB +: IDX_W];
    byte_off  = Haddr[LSB-1:0];
    size_eff  = (Hsize > 3'(LSB)) ? 3'(LSB) : Hsize;
    size_mask = LSB'((8'd1 << size_eff) - 8'd1);
    lane_ones = (16'd1 << (5'd1 << size_eff)) - 16'd1;
    // Lanes come from the size-aligned address so unaligned requests never straddle a word.
    acc_lanes = STRB_W'(lane_ones << (byte_off & ~size_mask));
`ifdef AHB_SLV_ERR_EN
    illegal = (Hsize > 3'(LSB)) || ((byte_off & size_mask) != '0) ||
              ((Haddr >> LSB) >= ADDR_WIDTH'(MEM_DEPTH));
`else
    illegal = 1'b0;
`endif
  end

  assign final_cyc = (state_reg == WAIT) && (cnt_reg == 4'd0);
  assign wr_commit = final_cyc & write_reg;
  assign wr_be     = lanes_reg & Hstrob;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    Hreadyout  = 1'b1;
    Hresp      = 2'b00;
    case (state_reg)
      WAIT: begin
        if (cnt_reg != 4'd0) begin
          Hreadyout = 1'b0;
          cnt_next  = cnt_reg - 4'd1;
        end else begin
          state_next = IDLE;
        end
      end
`ifdef AHB_SLV_ERR_EN
      ERR1: begin
        Hreadyout  = 1'b0;
        Hresp      = 2'b01;
        state_next = ERR2;
      end
      ERR2: begin
        Hresp      = 2'b01;
        state_next = IDLE;
      end
`endif
      default: ;
    endcase
    take = accept & Hreadyout;
    if (take) begin
      state_next = illegal ? ERR1 : WAIT;
      cnt_next   = illegal ? 4'd0 : WAIT_LOAD;
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      write_reg    <= 1'b0;
      lanes_reg    <= '0;
      idx_reg      <= '0;
      fwd_mask_reg <= '0;
      fwd_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (take) begin
        write_reg    <= Hwrite;
        lanes_reg    <= acc_lanes;
        idx_reg      <= acc_idx;
        // The RAM read below sees the pre-write word; remember the lanes being committed now.
        fwd_mask_reg <= (wr_commit && (idx_reg == acc_idx)) ? wr_be : '0;
        fwd_data_reg <= HWdata;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] mem [MEM_DEPTH];
      logic [7:0] rd_reg;
      always_ff @(posedge Hclk) begin
        if (wr_commit && wr_be[gi]) mem[idx_reg] <= HWdata[gi*8 +: 8];
        if (take) rd_reg <= mem[acc_idx];
      end
      assign rd_word[gi*8 +: 8]  = rd_reg;
      assign fwd_bits[gi*8 +: 8] = {8{fwd_mask_reg[gi]}};
    end
  endgenerate

  always_comb begin
    HRdata = '0;
    if (final_cyc && !write_reg) HRdata = (rd_word & ~fwd_bits) | (fwd_data_reg & fwd_bits);
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: a zero-wait and a two-wait instance, scoreboard of data phases.
module tb_ahb_sram_slave;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hstrob;
  logic        hsel0, hsel2;
  logic [31:0] rdata0, rdata2;
  logic        ro0, ro2;
  logic [1:0]  resp0, resp2;

  ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .Hclk(clk), .Hreset(rst), .Haddr(haddr), .Htrans(htrans), .Hwrite(hwrite), .Hsize(hsize),
    .Hburst(hburst), .HWdata(hwdata), .Hstrob(hstrob), .Hsel(hsel0), .Hready(ro0),
    .HRdata(rdata0), .Hreadyout(ro0), .Hresp(resp0));

  ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) u_dut2 (
    .Hclk(clk), .Hreset(rst), .Haddr(haddr), .Htrans(htrans), .Hwrite(hwrite), .Hsize(hsize),
    .Hburst(hburst), .HWdata(hwdata), .Hstrob(hstrob), .Hsel(hsel2), .Hready(ro2),
    .HRdata(rdata2), .Hreadyout(ro2), .Hresp(resp2));

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic [1:0]  resp;
    int          waits;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] mdl[int];
  int          which = 0;
  bit          dp_valid = 1'b0;
  int          wait_cnt = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  logic [31:0] cur_rdata;
  logic        cur_ro;
  logic [1:0]  cur_resp;
  always_comb begin
    cur_rdata = (which == 2) ? rdata2 : rdata0;
    cur_ro    = (which == 2) ? ro2 : ro0;
    cur_resp  = (which == 2) ? resp2 : resp0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Watch the data phase in flight until the selected slave is ready (bounded).
  task automatic dp_wait();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dp_valid && sb.size() > 0) begin
        if (cur_ro) begin
          check({sb[0].tag, " rdata"}, cur_rdata, sb[0].rd);
          check({sb[0].tag, " resp"}, 32'(cur_resp), 32'(sb[0].resp));
          check({sb[0].tag, " waits"}, 32'(wait_cnt), 32'(sb[0].waits));
          sb.delete(0);
          wait_cnt = 0;
          dp_valid = 1'b0;
          ok = 1'b1;
          break;
        end else begin
          check({sb[0].tag, " wait rdata"}, cur_rdata, 32'h0);
          check({sb[0].tag, " wait resp"}, 32'(cur_resp), 32'(sb[0].resp));
          wait_cnt++;
        end
      end else if (cur_ro) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL timeout: Hreadyout observed 0 for 20 cycles, required 1");
    end
  endtask

  task automatic issue(input logic sel, input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [1:0] trans, input logic [31:0] wdata, input logic [3:0] strob,
                       input string tag);
    sb_t         e;
    bit          active, bad;
    int          key, nb, off;
    logic [31:0] w;
    active = sel && trans[1];
    bad    = 1'b0;
`ifdef AHB_SLV_ERR_EN
    bad = active && ((size > 3'd2) || ((addr & ((32'd1 << size) - 32'd1)) != 32'd0) ||
                     ((addr >> 2) >= 32'd1024));
`endif
    e.tag   = tag;
    e.resp  = bad ? 2'b01 : 2'b00;
    e.waits = bad ? 1 : ((active && which == 2) ? 2 : 0);
    e.rd    = 32'h0;
    if (active && !bad) begin
      key = which * 4096 + (int'(addr >> 2) % 1024);
      if (wr) begin
        w   = mdl.exists(key) ? mdl[key] : 32'h0;
        nb  = 1 << ((size > 3'd2) ? 2 : int'(size));
        off = int'(addr[1:0]) & ~(nb - 1);
        for (int b = 0; b < 4; b++)
          if (b >= off && b < off + nb && strob[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
        mdl[key] = w;
      end else begin
        e.rd = mdl[key];
      end
    end
    sb.push_back(e);
    hsel0  = sel && (which == 0);
    hsel2  = sel && (which == 2);
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    htrans = trans;
    dp_wait();
    @(posedge clk);
    #1;
    hwdata   = wdata;
    hstrob   = strob;
    dp_valid = 1'b1;
  endtask

  task automatic drain();
    hsel0  = 1'b0;
    hsel2  = 1'b0;
    htrans = T_IDLE;
    dp_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time observed 200000, required completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; haddr = '0; hwdata = '0; htrans = T_IDLE; hwrite = 1'b0;
    hsize = 3'd2; hburst = 3'd0; hstrob = 4'hF; hsel0 = 1'b0; hsel2 = 1'b0;
    #3;
    check("reset ro0", 32'(ro0), 32'h1);
    check("reset resp0", 32'(resp0), 32'h0);
    check("reset rdata0", rdata0, 32'h0);
    check("reset ro2", 32'(ro2), 32'h1);
    check("reset resp2", 32'(resp2), 32'h0);
    check("reset rdata2", rdata2, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait write then forwarded read, plus back-to-back streaming.
    which = 0;
    issue(1, 32'h10, 1, 3'd2, T_NSEQ, 32'hDEADBEEF, 4'hF, "t1 wr 0x10");
    issue(1, 32'h10, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "t1 rd 0x10");
    issue(1, 32'h14, 1, 3'd2, T_NSEQ, 32'h01234567, 4'hF, "t1 wr 0x14");
    issue(1, 32'h18, 1, 3'd2, T_NSEQ, 32'h89ABCDEF, 4'hF, "t1 wr 0x18");
    issue(1, 32'h14, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "t1 rd 0x14");
    issue(1, 32'h18, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "t1 rd 0x18");
    issue(0, 32'h10, 1, 3'd2, T_NSEQ, 32'h0, 4'hF, "unsel wr 0x10");
    issue(1, 32'h10, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "unsel rd 0x10");
    drain();

    // Byte/halfword lanes and strobes.
    issue(1, 32'h30, 1, 3'd2, T_NSEQ, 32'h11223344, 4'hF, "t3 wr 0x30");
    issue(1, 32'h31, 1, 3'd0, T_NSEQ, 32'h0000AA00, 4'hF, "t3 byte 0x31");
    issue(1, 32'h30, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "t3 rd fwd");
    issue(1, 32'h30, 1, 3'd2, T_NSEQ, 32'hFFFFFFFF, 4'h0, "t3 strob0");
    issue(T_IDLE == 2'b00, 32'h0, 0, 3'd2, T_IDLE, 32'h0, 4'hF, "t3 idle");
    issue(1, 32'h30, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "t3 rd 0x30");
    issue(1, 32'h32, 1, 3'd1, T_NSEQ, 32'h5A5A0000, 4'hC, "t3 half 0x32");
    issue(1, 32'h30, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "t3 rd half");
    drain();

    // INCR4 with a BUSY beat inserted.
    hburst = 3'd3;
    issue(1, 32'h50, 1, 3'd2, T_NSEQ, 32'hA0A0A0A0, 4'hF, "t6 beat0");
    issue(1, 32'h54, 1, 3'd2, T_SEQ,  32'hA1A1A1A1, 4'hF, "t6 beat1");
    issue(1, 32'h58, 1, 3'd2, T_BUSY, 32'hEEEEEEEE, 4'hF, "t6 busy");
    issue(1, 32'h58, 1, 3'd2, T_SEQ,  32'hA2A2A2A2, 4'hF, "t6 beat2");
    issue(1, 32'h5C, 1, 3'd2, T_SEQ,  32'hA3A3A3A3, 4'hF, "t6 beat3");
    hburst = 3'd0;
    for (int i = 0; i < 4; i++)
      issue(1, 32'h50 + 32'(4 * i), 0, 3'd2, T_NSEQ, 32'h0, 4'hF, $sformatf("t6 rd %0d", i));
    drain();

`ifdef AHB_SLV_ERR_EN
    issue(1, 32'h0, 1, 3'd2, T_NSEQ, 32'h0BADF00D, 4'hF, "t4 wr 0x0");
    issue(1, 32'h1000, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "t4 rd 0x1000");
    issue(1, 32'h2, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "t4 rd unaligned");
    issue(1, 32'h1000, 1, 3'd2, T_NSEQ, 32'hFFFFFFFF, 4'hF, "t4 wr 0x1000");
    issue(1, 32'h4, 0, 3'd3, T_NSEQ, 32'h0, 4'hF, "t4 rd size3");
    issue(1, 32'h0, 0, 3'd0, T_IDLE, 32'h0, 4'hF, "t4 idle");
    issue(1, 32'h0, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "t4 rd 0x0");
    drain();
`else
    issue(1, 32'h60, 1, 3'd3, T_NSEQ, 32'h01020304, 4'hF, "clamp wr size3");
    issue(1, 32'h60, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "clamp rd");
    issue(1, 32'h61, 1, 3'd1, T_NSEQ, 32'h0000BEEF, 4'hF, "unalign half");
    issue(1, 32'h60, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "unalign rd");
    issue(1, 32'h1064, 1, 3'd2, T_NSEQ, 32'h77777777, 4'hF, "alias wr");
    issue(1, 32'h64, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "alias rd");
    drain();
`endif

    // Two wait states, including forwarding across the waits.
    which = 2;
    issue(1, 32'h20, 1, 3'd2, T_NSEQ, 32'hCAFEF00D, 4'hF, "t2 wr 0x20");
    issue(1, 32'h0, 0, 3'd2, T_IDLE, 32'h0, 4'hF, "t2 idle");
    issue(1, 32'h20, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "t2 rd 0x20");
    issue(1, 32'h24, 1, 3'd2, T_NSEQ, 32'h13579BDF, 4'hF, "t2 wr 0x24");
    issue(1, 32'h24, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "t2 rd fwd");
    issue(1, 32'h40, 1, 3'd2, T_NSEQ, 32'h12345678, 4'hF, "t5 pre wr");
    drain();

    // Reset lands in the first wait cycle of a write; the write must be dropped.
    issue(1, 32'h40, 1, 3'd2, T_NSEQ, 32'h00000055, 4'hF, "t5 wr");
    mdl[2 * 4096 + 16] = 32'h12345678;
    hsel2 = 1'b0; htrans = T_IDLE;
    #2;
    check("t5 in wait ro2", 32'(ro2), 32'h0);
    rst = 1'b1;
    #1;
    check("t5 rst ro2", 32'(ro2), 32'h1);
    check("t5 rst resp2", 32'(resp2), 32'h0);
    check("t5 rst rdata2", rdata2, 32'h0);
    check("t5 rst ro0", 32'(ro0), 32'h1);
    sb.delete();
    dp_valid = 1'b0;
    wait_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    issue(1, 32'h40, 0, 3'd2, T_NSEQ, 32'h0, 4'hF, "t5 rd 0x40");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
